fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage sitting between the program counter register and the IF/ID boundary.
- Drives the PC register's write enable and next-PC value.
- Fetches from a variable-latency instruction memory over a req/ack handshake and presents the fetched word to decode.
- Absorbs decode stalls via a one-entry hold buffer; redirects on branch flush, including while a memory access is outstanding.

Parameters:
- RESET_VECTOR, 32'h0000_0000, address loaded into the PC during reset.
- NOP_WORD, 32'h0000_0000, instruction placed on ifid_instr when a bubble is inserted.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- resetn  in  1  synchronous, active-low reset.
- pc  in  32  current PC register value.
- PCWrite  out  1  PC register write enable (combinational).
- nextpc  out  32  value the PC register loads when PCWrite=1 (combinational).
- stall  in  1  decode hazard; IF/ID must hold its contents.
- flush  in  1  branch/jump resolved taken; redirect fetch.
- branch_target  in  32  redirect address, valid when flush=1.
- imem_req  out  1  memory request.
- imem_addr  out  32  registered request address; stable while imem_req=1 until ack.
- imem_ack  in  1  rdata valid this cycle for imem_addr.
- imem_rdata  in  32  fetched instruction.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  32  fetched instruction.
- ifid_pc4  out  32  fetch address + PC_STEP.

Behaviour:
- States: S_REQ, S_HOLD, S_DRAIN; state and the hold buffer (buf_instr, buf_pc4) are registered.
- Reset (resetn=0 at posedge):
  - State <= S_REQ; req_addr <= RESET_VECTOR.
  - ifid_valid <= 0; ifid_instr <= NOP_WORD; ifid_pc4 <= 0.
  - Combinationally while resetn=0: PCWrite=1, nextpc=RESET_VECTOR, imem_req=0.
- imem_req=1 in S_REQ and S_DRAIN; 0 in S_HOLD. imem_addr = req_addr always.
- Defaults unless a rule below overrides:
  - PCWrite=0, nextpc=pc+PC_STEP (mod 2^32, wraps silently).
  - IF/ID: hold when stall=1; when stall=0, ifid_valid <= 0 and ifid_instr <= NOP_WORD (bubble).
- Flush has priority over everything, in every state:
  - PCWrite=1, nextpc=branch_target.
  - ifid_valid <= 0, ifid_instr <= NOP_WORD, even if stall=1.
  - Hold buffer is discarded.
  - If in S_REQ with ack=1, or in S_HOLD: next state S_REQ, req_addr <= branch_target.
  - If in S_REQ with ack=0, or in S_DRAIN: next state S_DRAIN; the outstanding access must complete before the address changes.
- S_REQ, ack=1, stall=0:
  - ifid_instr <= rdata, ifid_pc4 <= req_addr+PC_STEP, ifid_valid <= 1.
  - PCWrite=1; req_addr <= pc+PC_STEP; stay in S_REQ.
  - Back-to-back throughput is 1 instr/cycle with a zero-wait memory.
- S_REQ, ack=1, stall=1:
  - buf <= {rdata, req_addr+PC_STEP}; IF/ID holds; PCWrite=0; next state S_HOLD.
- S_REQ, ack=0: remain in S_REQ; IF/ID per defaults.
- S_HOLD, stall=0:
  - IF/ID <= buf with ifid_valid=1; PCWrite=1; req_addr <= pc+PC_STEP; next state S_REQ.
- S_HOLD, stall=1: remain in S_HOLD; everything holds.
- S_DRAIN, ack=1:
  - rdata is discarded; req_addr <= pc (already the redirect target); next state S_REQ.
  - imem_req stays 1 across this transition.
- S_DRAIN, ack=0: remain in S_DRAIN. A repeated flush updates pc again; the last target wins.
- Invariant: pc == req_addr in S_REQ except in the cycle of a flush.
- Reset mid-access: the outstanding request is abandoned (imem_req drops). The memory must treat imem_req=0 as abort.

Decomposition:
- Shared pipeline package holds:
  - state encoding for S_REQ/S_HOLD/S_DRAIN;
  - NOP_WORD and PC_STEP constants;
  - an IF/ID record typedef {valid, instr, pc4} reused by the decode stage.
- No sub-module; the hold buffer is two registers and stays inline.

Test Plan:
- Reset then zero-wait memory (ack=1 every cycle), rdata = addr: PC sequence 0,4,8; ifid_instr = 0,4,8 on consecutive cycles; ifid_pc4 = 4,8,12.
- Ack with 2 wait cycles at addr 0x10: imem_addr stays 0x10 for 3 cycles; PCWrite=0 for the first two; two bubbles (ifid_valid=0, instr=NOP_WORD); then instr at 0x10 appears.
- Stall asserted in the ack cycle for 0x20, held 3 cycles: IF/ID keeps the prior instruction; the 0x20 word enters IF/ID the cycle after stall drops; pc stays 0x20 until then, then becomes 0x24.
- Flush (target 0x100) while 0x40 is outstanding with ack delayed 2 cycles: pc=0x100 next cycle; imem_addr holds 0x40 until ack; 0x40 data never reaches IF/ID; next request address is 0x100.
- Flush and stall together in S_HOLD with target 0x200: ifid_valid=0; buffered word dropped; next imem_addr=0x200.
- pc=0xFFFF_FFFC with ack and no stall: nextpc=0x0000_0000 and ifid_pc4=0x0000_0000; a mid-stream resetn=0 gives imem_req=0 and nextpc=RESET_VECTOR in the same cycle.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and the IF/ID boundary.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] IF_NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] IF_PC_STEP  = 32'd4;

    // IF/ID pipeline record, also consumed by the decode stage.
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
    } ifid_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: drives the PC register, talks to a variable-latency
// instruction memory, and feeds IF/ID with a one-entry stall buffer.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD     = IF_NOP_WORD,
    parameter logic [31:0] PC_STEP      = IF_PC_STEP
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] pc,
    output logic        PCWrite,
    output logic [31:0] nextpc,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  req_addr_reg, req_addr_next;
    ifid_t        ifid_reg, ifid_next;
    logic [31:0]  buf_instr_reg, buf_instr_next;
    logic [31:0]  buf_pc4_reg, buf_pc4_next;

    logic [31:0] pc_plus_step;
    logic [31:0] req_plus_step;

    assign pc_plus_step  = pc + PC_STEP;
    assign req_plus_step = req_addr_reg + PC_STEP;

    assign imem_req   = resetn && (state_reg != S_HOLD);
    assign imem_addr  = req_addr_reg;
    assign ifid_valid = ifid_reg.valid;
    assign ifid_instr = ifid_reg.instr;
    assign ifid_pc4   = ifid_reg.pc4;

    always_comb begin
        state_next     = state_reg;
        req_addr_next  = req_addr_reg;
        buf_instr_next = buf_instr_reg;
        buf_pc4_next   = buf_pc4_reg;
        PCWrite        = 1'b0;
        nextpc         = pc_plus_step;
        if (stall) begin
            ifid_next = ifid_reg;
        end else begin
            ifid_next = '{valid: 1'b0, instr: NOP_WORD, pc4: ifid_reg.pc4};
        end

        if (!resetn) begin
            PCWrite = 1'b1;
            nextpc  = RESET_VECTOR;
        end else if (flush) begin
            PCWrite   = 1'b1;
            nextpc    = branch_target;
            ifid_next = '{valid: 1'b0, instr: NOP_WORD, pc4: ifid_reg.pc4};
            // An access still in flight must finish at its old address before redirecting.
            case (state_reg)
                S_REQ: begin
                    if (imem_ack) begin
                        state_next    = S_REQ;
                        req_addr_next = branch_target;
                    end else begin
                        state_next = S_DRAIN;
                    end
                end
                S_HOLD: begin
                    state_next    = S_REQ;
                    req_addr_next = branch_target;
                end
                default: state_next = S_DRAIN;
            endcase
        end else begin
            case (state_reg)
                S_REQ: begin
                    if (imem_ack) begin
                        if (!stall) begin
                            ifid_next     = '{valid: 1'b1, instr: imem_rdata, pc4: req_plus_step};
                            PCWrite       = 1'b1;
                            req_addr_next = pc_plus_step;
                        end else begin
                            buf_instr_next = imem_rdata;
                            buf_pc4_next   = req_plus_step;
                            state_next     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ifid_next     = '{valid: 1'b1, instr: buf_instr_reg, pc4: buf_pc4_reg};
                        PCWrite       = 1'b1;
                        req_addr_next = pc_plus_step;
                        state_next    = S_REQ;
                    end
                end
                S_DRAIN: begin
                    // pc already holds the last redirect target.
                    if (imem_ack) begin
                        req_addr_next = pc;
                        state_next    = S_REQ;
                    end
                end
                default: state_next = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg    <= S_REQ;
            req_addr_reg <= RESET_VECTOR;
            ifid_reg     <= '{valid: 1'b0, instr: NOP_WORD, pc4: 32'h0000_0000};
        end else begin
            state_reg    <= state_next;
            req_addr_reg <= req_addr_next;
            ifid_reg     <= ifid_next;
        end
    end

    always_ff @(posedge clock) begin
        buf_instr_reg <= buf_instr_next;
        buf_pc4_reg   <= buf_pc4_next;
    end

endmodule
